// File: rtl/sr_chain.sv
// rtl/sr_chain.sv - variable-tap shift register chain with recirculate, hold and flush
module sr_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 128,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [LW-1:0]    len,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [LW-1:0]    fill,
  output logic             busy
);

  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_RECIRC = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t           state;
  logic [WIDTH-1:0] stage [DEPTH];
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    fill_q;
  logic [LW-1:0]    flush_cnt;
  logic [LW-1:0]    len_eff;
  logic [WIDTH-1:0] tap;
  logic [WIDTH-1:0] shift_word;
  logic             do_shift;

  always_comb begin
    len_eff = len;
    if (len == '0)
      len_eff = LW'(1);
    else if (len > LW'(DEPTH))
      len_eff = LW'(DEPTH);
  end

  // Tap mux at stage len_q-1; len_q is always in 1..DEPTH
  always_comb begin
    tap = stage[0];
    for (int k = 0; k < DEPTH; k++) begin
      if (len_q == LW'(k + 1))
        tap = stage[k];
    end
  end

  always_comb begin
    do_shift   = 1'b0;
    shift_word = din;
    if (state == S_FLUSH) begin
      do_shift   = 1'b1;
      shift_word = '0;
    end else if (mode == MODE_SHIFT) begin
      do_shift = en;
    end else if (mode == MODE_RECIRC) begin
      do_shift   = en;
      shift_word = tap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        stage[k] <= '0;
    end else if (do_shift) begin
      stage[0] <= shift_word;
      for (int k = 1; k < DEPTH; k++)
        stage[k] <= stage[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      len_q     <= LW'(DEPTH);
      fill_q    <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          case (mode)
            MODE_SHIFT: begin
              if (en && (fill_q < len_q))
                fill_q <= fill_q + LW'(1);
            end
            MODE_RECIRC: begin
            end
            MODE_HOLD: begin
              len_q <= len_eff;
              if (fill_q > len_eff)
                fill_q <= len_eff;
            end
            default: begin
              state     <= S_FLUSH;
              flush_cnt <= len_q;
            end
          endcase
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt - LW'(1);
          if (fill_q != '0)
            fill_q <= fill_q - LW'(1);
          if (flush_cnt <= LW'(1))
            state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign dout       = tap;
  assign fill       = fill_q;
  assign busy       = (state == S_FLUSH);
  assign dout_valid = (state == S_RUN) && (fill_q == len_q);

endmodule

// File: doc/sr_chain.md
SR_CHAIN -- requirements
Module: sr_chain

Interface
REQ-001 Parameter WIDTH, default 1, bits per stage (lane count).
REQ-002 Parameter DEPTH, default 128, physical stage count; DEPTH >= 2.
REQ-003 Derived constant LW = $clog2(DEPTH+1), width of length and fill fields; not overridable.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  shift strobe; one shift per cycle when high in SHIFT/RECIRC mode.
REQ-007 mode  input  2  00 SHIFT, 01 RECIRC, 10 HOLD, 11 FLUSH request.
REQ-008 len  input  LW  requested active length (tap position).
REQ-009 din  input  WIDTH  serial data word entering stage 0.
REQ-010 dout  output  WIDTH  word at stage len_q-1.
REQ-011 dout_valid  output  1  high when chain holds len_q real words.
REQ-012 fill  output  LW  count of valid words in active length.
REQ-013 busy  output  1  high while flush in progress.

Function
REQ-014 Storage: stages s[0..DEPTH-1], each WIDTH bits, flip-flop based; no latches.
REQ-015 Internal len_q (LW bits) is the active length; len_eff = len clamped to range 1..DEPTH (0 -> 1, >DEPTH -> DEPTH).
REQ-016 len_q loads len_eff only in cycles with state RUN and mode=HOLD; len changes in any other mode are ignored.
REQ-017 FSM has two states: RUN and FLUSH.
REQ-018 RUN, mode=SHIFT, en=1: s[0]<=din, s[k]<=s[k-1] for all k>=1; fill<=min(fill+1, len_q).
REQ-019 RUN, mode=RECIRC, en=1: s[0]<=s[len_q-1], s[k]<=s[k-1] for k>=1; din ignored; fill unchanged.
REQ-020 RUN, SHIFT or RECIRC with en=0: all stages and fill hold.
REQ-021 RUN, mode=HOLD: stages hold regardless of en; on len_q update, fill<=min(fill, len_eff) in the same edge.
REQ-022 RUN, mode=FLUSH: transition to FLUSH; flush counter loads len_q; no shift on this edge.
REQ-023 FLUSH state: every cycle, regardless of en and mode: s[0]<=0, s[k]<=s[k-1]; counter and fill decrement (fill saturates at 0).
REQ-024 FLUSH exits to RUN on the edge where counter reaches 0, i.e. after exactly len_q zero-shifts; stages 0..len_q-1 are then zero and fill=0.
REQ-025 busy = (state==FLUSH); len, din, en, mode ignored while busy.
REQ-026 dout = s[len_q-1], combinational from registers; no extra output register.
REQ-027 Latency: a word shifted in with en arrives at dout after exactly len_q shift cycles (len_q=1: visible the cycle after its shift edge).
REQ-028 dout_valid = (fill==len_q) and state==RUN; forced 0 throughout FLUSH.
REQ-029 Stages beyond len_q-1 keep shifting in SHIFT/RECIRC/FLUSH; their content is never observable.
REQ-030 fill never exceeds len_q; no wrap-around on any counter.

Reset
REQ-031 rst=1 at a rising edge: all stages 0, len_q=DEPTH, fill=0, state=RUN, flush counter 0.
REQ-032 Outputs after reset: dout=0, dout_valid=0, fill=0, busy=0.
REQ-033 rst has priority over all inputs, including mid-flush; flush aborts, FSM returns to RUN.

Verification
REQ-034 DEPTH=8, WIDTH=4, rst, HOLD with len=3, SHIFT din=1,2,3 with en=1 -> after third shift dout=1, fill=3, dout_valid=1; next shift din=4 -> dout=2.
REQ-035 Same config, stream 1..3 loaded, RECIRC en=1 for 3 cycles -> dout sequence 2,3,1; fill stays 3; din toggling has no effect.
REQ-036 len=3, chain full, FLUSH request -> busy=1 for exactly 3 cycles, dout_valid=0 throughout, then dout=0, fill=0, busy=0.
REQ-037 HOLD with len=0 -> len_q=1; len=9 -> len_q=8; fill=5 then HOLD len=2 -> fill=2, dout_valid=1.
REQ-038 SHIFT with en toggling 1,0,1,0 on din=A,B,C,D, len=2 -> only A and C captured; dout=A after second captured shift.
REQ-039 rst asserted on second flush cycle -> next cycle busy=0, fill=0, dout=0, len_q=8.
